// File: rtl/gen_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gen_pad_pkg
// Description : Shared types and constants for the Mega Drive pad poller.
// Revision    : 1.0 - initial release
// ============================================================================
package gen_pad_pkg;

    // Phase index within one poll frame (0..7)
    typedef logic [2:0] phase_t;

    localparam phase_t PH_BC   = 3'd0;  // TH=1: directions, B, C
    localparam phase_t PH_AS   = 3'd1;  // TH=0: A, START, presence
    localparam phase_t PH_SIX  = 3'd5;  // TH=0: 6-button signature
    localparam phase_t PH_XYZ  = 3'd6;  // TH=1: X, Y, Z, MODE
    localparam phase_t PH_LAST = 3'd7;

    // PAD_DI bit positions
    localparam int DI_D0 = 0;
    localparam int DI_D1 = 1;
    localparam int DI_D2 = 2;
    localparam int DI_D3 = 3;
    localparam int DI_TL = 4;
    localparam int DI_TR = 5;

    // Decoded buttons, 1 = pressed, UP in the MSB
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic a;
        logic b;
        logic c;
        logic start;
        logic mode;
        logic x;
        logic y;
        logic z;
    } buttons_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PHASE = 1'b1
    } state_t;

    // Drop the buttons that only a 6-button pad can report
    function automatic buttons_t clear_six(input buttons_t b);
        buttons_t r;
        r      = b;
        r.mode = 1'b0;
        r.x    = 1'b0;
        r.y    = 1'b0;
        r.z    = 1'b0;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pad_sync.sv
`default_nettype none
// ============================================================================
// Module      : pad_sync
// Description : Two-flop synchronizer; resets to all-ones (released pins).
// Revision    : 1.0 - initial release
// ============================================================================
module pad_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] stable;

    // Two-stage capture of the asynchronous pad pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '1;
            stable <= '1;
        end else begin
            meta   <= din;
            stable <= meta;
        end
    end

    assign dout = stable;

endmodule
`default_nettype wire

// File: rtl/gen_pad_reader.sv
`default_nettype none
// ============================================================================
// Module      : gen_pad_reader
// Description : Polls a Mega Drive 3/6-button pad through the 8-phase TH
//               sequence and publishes decoded, active-high button flags.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_pad_reader
    import gen_pad_pkg::*;
#(
    parameter int SETTLE     = 4,
    parameter int IDLE_TICKS = 20000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CE,
    input  logic       J3BUT,
    input  logic [5:0] PAD_DI,
    output logic       PAD_TH,
    output logic       P_UP,
    output logic       P_DOWN,
    output logic       P_LEFT,
    output logic       P_RIGHT,
    output logic       P_A,
    output logic       P_B,
    output logic       P_C,
    output logic       P_START,
    output logic       P_MODE,
    output logic       P_X,
    output logic       P_Y,
    output logic       P_Z,
    output logic       PRESENT,
    output logic       SIX_BTN,
    output logic       VALID
);

    localparam int CNT_MAX = (IDLE_TICKS > SETTLE) ? IDLE_TICKS : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] IDLE_END   = CNT_W'(IDLE_TICKS - 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);

    logic [5:0]       di_sync;
    logic [5:0]       pressed;

    state_t           state, state_d;
    logic [CNT_W-1:0] tick_cnt, tick_cnt_d;
    phase_t           phase, phase_d;
    logic             j3_frame, j3_frame_d;
    logic             frame_start;
    logic             sample_stb;
    logic             last_stb;

    // Sample strobes delayed to line up with the synchronizer latency
    logic             s1_vld, s1_last, s2_vld, s2_last;
    phase_t           s1_phase, s2_phase;

    buttons_t         shadow, shadow_d;
    logic             pres, pres_d;
    logic             six, six_d;
    buttons_t         btn_out;

    pad_sync #(.WIDTH(6)) u_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .din   (PAD_DI),
        .dout  (di_sync)
    );

    assign pressed = ~di_sync;

    // TH high while idle, otherwise alternates with the phase index
    assign PAD_TH = (state == ST_PHASE) ? ~phase[0] : 1'b1;

    // Frame sequencer registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            phase    <= PH_BC;
            j3_frame <= 1'b0;
        end else begin
            state    <= state_d;
            tick_cnt <= tick_cnt_d;
            phase    <= phase_d;
            j3_frame <= j3_frame_d;
        end
    end

    // Frame sequencer next-state: idle wait, then SETTLE ticks per phase
    always_comb begin
        state_d     = state;
        tick_cnt_d  = tick_cnt;
        phase_d     = phase;
        j3_frame_d  = j3_frame;
        frame_start = 1'b0;
        sample_stb  = 1'b0;
        last_stb    = 1'b0;
        if (CE) begin
            case (state)
                ST_IDLE: begin
                    if (tick_cnt == IDLE_END) begin
                        state_d     = ST_PHASE;
                        tick_cnt_d  = '0;
                        phase_d     = PH_BC;
                        j3_frame_d  = J3BUT;
                        frame_start = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt + CNT_W'(1);
                    end
                end
                ST_PHASE: begin
                    if (tick_cnt == SETTLE_END) begin
                        sample_stb = 1'b1;
                        tick_cnt_d = '0;
                        if (phase == PH_LAST || (j3_frame && phase == PH_AS)) begin
                            last_stb = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            phase_d = phase + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Delay the sample point two CLKs so the synchronized pins reflect
    // the pad state at the last tick of the phase
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_vld   <= 1'b0;
            s1_last  <= 1'b0;
            s1_phase <= PH_BC;
            s2_vld   <= 1'b0;
            s2_last  <= 1'b0;
            s2_phase <= PH_BC;
        end else begin
            s1_vld   <= sample_stb;
            s1_last  <= last_stb;
            s1_phase <= phase;
            s2_vld   <= s1_vld;
            s2_last  <= s1_last;
            s2_phase <= s1_phase;
        end
    end

    // Per-phase capture into the shadow set
    always_comb begin
        shadow_d = shadow;
        pres_d   = pres;
        six_d    = six;
        if (s2_vld) begin
            case (s2_phase)
                PH_BC: begin
                    shadow_d.up    = pressed[DI_D0];
                    shadow_d.down  = pressed[DI_D1];
                    shadow_d.left  = pressed[DI_D2];
                    shadow_d.right = pressed[DI_D3];
                    shadow_d.b     = pressed[DI_TL];
                    shadow_d.c     = pressed[DI_TR];
                end
                PH_AS: begin
                    shadow_d.a     = pressed[DI_TL];
                    shadow_d.start = pressed[DI_TR];
                    pres_d         = pressed[DI_D2] & pressed[DI_D3];
                end
                PH_SIX: begin
                    six_d = &pressed[DI_D3:DI_D0];
                end
                PH_XYZ: begin
                    if (six) begin
                        shadow_d.z    = pressed[DI_D0];
                        shadow_d.y    = pressed[DI_D1];
                        shadow_d.x    = pressed[DI_D2];
                        shadow_d.mode = pressed[DI_D3];
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow registers: cleared at frame start, updated on each sample
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            shadow <= '0;
            pres   <= 1'b0;
            six    <= 1'b0;
        end else if (frame_start) begin
            shadow <= '0;
            pres   <= 1'b0;
            six    <= 1'b0;
        end else begin
            shadow <= shadow_d;
            pres   <= pres_d;
            six    <= six_d;
        end
    end

    // Atomic output update with masking at the end of each frame
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            btn_out <= '0;
            PRESENT <= 1'b0;
            SIX_BTN <= 1'b0;
            VALID   <= 1'b0;
        end else begin
            VALID <= s2_vld & s2_last;
            if (s2_vld && s2_last) begin
                PRESENT <= pres_d;
                SIX_BTN <= pres_d & six_d & ~j3_frame;
                if (!pres_d) begin
                    btn_out <= '0;
                end else if (six_d && !j3_frame) begin
                    btn_out <= shadow_d;
                end else begin
                    btn_out <= clear_six(shadow_d);
                end
            end
        end
    end

    assign P_UP    = btn_out.up;
    assign P_DOWN  = btn_out.down;
    assign P_LEFT  = btn_out.left;
    assign P_RIGHT = btn_out.right;
    assign P_A     = btn_out.a;
    assign P_B     = btn_out.b;
    assign P_C     = btn_out.c;
    assign P_START = btn_out.start;
    assign P_MODE  = btn_out.mode;
    assign P_X     = btn_out.x;
    assign P_Y     = btn_out.y;
    assign P_Z     = btn_out.z;

endmodule
`default_nettype wire

// File: tb/tb_gen_pad_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_gen_pad_reader
// Description : Self-checking bench for gen_pad_reader with a behavioural
//               Mega Drive pad model and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_pad_reader;

    localparam int SETTLE     = 2;
    localparam int IDLE_TICKS = 10;
    localparam int K_NONE  = 0;
    localparam int K_THREE = 1;
    localparam int K_SIX   = 2;

    logic       CLK;
    logic       RESET_N;
    logic       CE;
    logic       J3BUT;
    logic [5:0] PAD_DI;
    logic       PAD_TH;
    logic       P_UP, P_DOWN, P_LEFT, P_RIGHT, P_A, P_B, P_C, P_START;
    logic       P_MODE, P_X, P_Y, P_Z;
    logic       PRESENT, SIX_BTN, VALID;

    int          n_cmp = 0;
    int          n_err = 0;
    int          ce_div = 1;
    int          kind = K_SIX;
    logic [11:0] btn = 12'h000;   // bit 11 = UP ... bit 0 = Z
    int          fall_cnt = 0;
    int          hi_cnt = 0;
    logic        th_seen = 1'b1;
    logic [5:0]  prs;
    logic        th_last = 1'b1;
    int          falls, lows;
    logic [13:0] held = '0;
    logic        unstable;

    gen_pad_reader #(.SETTLE(SETTLE), .IDLE_TICKS(IDLE_TICKS)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .J3BUT(J3BUT), .PAD_DI(PAD_DI),
        .PAD_TH(PAD_TH), .P_UP(P_UP), .P_DOWN(P_DOWN), .P_LEFT(P_LEFT),
        .P_RIGHT(P_RIGHT), .P_A(P_A), .P_B(P_B), .P_C(P_C), .P_START(P_START),
        .P_MODE(P_MODE), .P_X(P_X), .P_Y(P_Y), .P_Z(P_Z),
        .PRESENT(PRESENT), .SIX_BTN(SIX_BTN), .VALID(VALID)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Tick enable: one CE every ce_div clocks
    initial begin
        int cyc;
        cyc = 0;
        CE  = 1'b1;
        forever begin
            @(negedge CLK);
            cyc = cyc + 1;
            CE  = ((cyc % ce_div) == 0);
        end
    end

    // Pad's internal TH counter: counts falling edges, clears after a long TH high
    initial begin
        forever begin
            @(posedge CLK or PAD_TH);
            if (PAD_TH !== th_seen) begin
                if (!PAD_TH) fall_cnt = fall_cnt + 1;
                th_seen = PAD_TH;
                hi_cnt  = 0;
            end else if (PAD_TH) begin
                hi_cnt = hi_cnt + 1;
                if (hi_cnt >= 8) fall_cnt = 0;
            end
        end
    end

    // Pad pin levels (prs = pin pulled low), order TR,TL,D3,D2,D1,D0
    always_comb begin
        prs = 6'b000000;
        if (kind == K_SIX) begin
            if (PAD_TH) begin
                if (fall_cnt == 3) prs = {btn[5], btn[6], btn[3], btn[2], btn[1], btn[0]};
                else               prs = {btn[5], btn[6], btn[8], btn[9], btn[10], btn[11]};
            end else begin
                if (fall_cnt == 3)      prs = {btn[4], btn[7], 4'b1111};
                else if (fall_cnt >= 4) prs = {btn[4], btn[7], 4'b0000};
                else                    prs = {btn[4], btn[7], 2'b11, btn[10], btn[11]};
            end
        end else if (kind == K_THREE) begin
            if (PAD_TH) begin
                prs = {btn[5], btn[6], btn[8], btn[9], btn[10], btn[11]};
                if (fall_cnt == 3) prs[3] = 1'b1;
            end else begin
                prs = {btn[4], btn[7], 2'b11, btn[10], btn[11]};
            end
        end
    end

    assign PAD_DI = ~prs;

    function automatic logic [13:0] observed();
        return {PRESENT, SIX_BTN, P_UP, P_DOWN, P_LEFT, P_RIGHT, P_A, P_B, P_C,
                P_START, P_MODE, P_X, P_Y, P_Z};
    endfunction

    // Reference: what one completed frame must publish
    function automatic logic [13:0] expected(input int k, input logic [11:0] b, input logic j3);
        logic six_ok;
        six_ok = (k == K_SIX) && !j3;
        if (k == K_NONE) return 14'h0000;
        return {1'b1, six_ok, six_ok ? b : {b[11:4], 4'b0000}};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for the next VALID, tracking TH activity and output stability
    task automatic wait_valid(output int clks, output bit ok);
        clks     = 0;
        ok       = 1'b0;
        falls    = 0;
        lows     = 0;
        unstable = 1'b0;
        while (!ok && clks < 2000) begin
            @(posedge CLK);
            #1;
            clks = clks + 1;
            if (clks == 1) check_val("valid_width", {31'd0, VALID}, 32'd0);
            else if (VALID) ok = 1'b1;
            if (!ok) begin
                if (observed() !== held) unstable = 1'b1;
                if (!PAD_TH) lows = lows + 1;
                if (th_last && !PAD_TH) falls = falls + 1;
            end
            th_last = PAD_TH;
        end
        if (!ok) check_val("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic j3, input int clks, input bit chk_len);
        int nph;
        nph = j3 ? 2 : 8;
        check_val({tag, "_outputs"}, {18'd0, observed()}, {18'd0, expected(kind, btn, j3)});
        check_val({tag, "_th_falls"}, falls, nph / 2);
        check_val({tag, "_th_low_clks"}, lows, (nph / 2) * SETTLE * ce_div);
        check_val({tag, "_stable"}, {31'd0, unstable}, 32'd0);
        if (chk_len) check_val({tag, "_frame_clks"}, clks, (IDLE_TICKS + nph * SETTLE) * ce_div);
        held = observed();
    endtask

    task automatic run_cfg(input string tag, input int k, input logic [11:0] b,
                           input logic j3, input int div, input int frames);
        int  clks;
        bit  ok;
        kind   = k;
        btn    = b;
        J3BUT  = j3;
        ce_div = div;
        for (int f = 0; f < frames; f++) begin
            wait_valid(clks, ok);
            if (ok) check_frame(tag, j3, clks, f > 0);
        end
    endtask

    initial begin
        int          clks;
        bit          ok;
        int          k;
        logic [11:0] b;
        int          tmo;

        RESET_N = 1'b0;
        J3BUT   = 1'b0;
        kind    = K_SIX;
        btn     = 12'h084;  // A + X
        repeat (3) @(posedge CLK);
        #1;
        check_val("reset_th", {31'd0, PAD_TH}, 32'd1);
        check_val("reset_outputs", {18'd0, observed()}, 32'd0);
        check_val("reset_valid", {31'd0, VALID}, 32'd0);

        @(negedge CLK);
        RESET_N = 1'b1;
        wait_valid(clks, ok);
        if (ok) begin
            check_val("first_latency", clks, IDLE_TICKS + 8 * SETTLE + 2);
            check_frame("six_ax_first", 1'b0, clks, 1'b0);
        end
        run_cfg("six_ax",   K_SIX,   12'h084, 1'b0, 1, 2);
        run_cfg("three_su", K_THREE, 12'h810, 1'b0, 1, 3);
        run_cfg("none",     K_NONE,  12'hFFF, 1'b0, 1, 3);
        run_cfg("six_j3",   K_SIX,   12'h084, 1'b1, 1, 3);
        run_cfg("six_ce3",  K_SIX,   12'h084, 1'b0, 3, 3);
        run_cfg("six_ax2",  K_SIX,   12'h084, 1'b0, 1, 2);

        // Reset while the pad is in phase 3 (second TH low)
        falls = 0;
        tmo   = 0;
        while (falls < 2 && tmo < 500) begin
            @(posedge CLK);
            #1;
            tmo = tmo + 1;
            if (th_last && !PAD_TH) falls = falls + 1;
            th_last = PAD_TH;
        end
        check_val("phase3_reached", falls, 2);
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check_val("midreset_th", {31'd0, PAD_TH}, 32'd1);
        check_val("midreset_outputs", {18'd0, observed()}, 32'd0);
        check_val("midreset_valid", {31'd0, VALID}, 32'd0);
        held = '0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            check_val("midreset_no_valid", {31'd0, VALID}, 32'd0);
        end
        @(negedge CLK);
        th_last = PAD_TH;
        RESET_N = 1'b1;
        wait_valid(clks, ok);
        if (ok) begin
            check_val("midreset_latency", clks, IDLE_TICKS + 8 * SETTLE + 2);
            check_frame("midreset_frame", 1'b0, clks, 1'b0);
        end

        // Randomized pads, buttons, mode and tick rate
        for (int i = 0; i < 14; i++) begin
            k = $urandom_range(0, 2);
            b = 12'($urandom);
            if (k == K_THREE && b[11] && b[10]) b[10] = 1'b0;
            run_cfg("rand", k, b, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
